// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared USB definitions for the device-side token receiver and the host
// packet encoder: 4-bit PID codes, CRC5 constants, the token decoder FSM
// state type and small PID classification helpers.
// -----------------------------------------------------------------------------
package usb_pkg;

  // PID[3:0] codes; the byte on the wire is {~pid, pid}.
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_PRE   = 4'b1100;
  localparam logic [3:0] PID_RSVD  = 4'b0000;

  // CRC5: x^5 + x^2 + 1, register preset to all ones, fed LSB first.
  // Running the received CRC field through the register leaves a fixed
  // residual when the packet is intact.
  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  // Token decoder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PID   = 3'd1,
    ST_B1    = 3'd2,
    ST_B2    = 3'd3,
    ST_CHECK = 3'd4,
    ST_DRAIN = 3'd5
  } tok_state_e;

  // True for the four token PIDs that carry an 11-bit field plus CRC5.
  function automatic logic is_token_pid(input logic [3:0] pid);
    logic res;
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: res = 1'b1;
      default:                             res = 1'b0;
    endcase
    return res;
  endfunction

  // PIDs that this receiver refuses outright (reserved code and PRE).
  function automatic logic is_illegal_pid(input logic [3:0] pid);
    logic res;
    case (pid)
      PID_RSVD, PID_PRE: res = 1'b1;
      default:           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/usb_crc5_byte.sv
// -----------------------------------------------------------------------------
// usb_crc5_byte
// Combinational CRC5 update over one byte, bits consumed LSB first.
// Shared between the device token decoder (checking) and the host packet
// encoder (generation).
//   crc_in   [4:0]  running CRC register value
//   data_in  [7:0]  byte to absorb, bit 0 is the first bit on the wire
//   crc_out  [4:0]  CRC register value after all 8 bits
// -----------------------------------------------------------------------------
module usb_crc5_byte
  import usb_pkg::*;
(
  input  logic [4:0] crc_in,
  input  logic [7:0] data_in,
  output logic [4:0] crc_out
);

  logic [4:0] crc_acc;

  // Unrolled bit-serial LFSR: feedback is the register MSB xor the next bit.
  always_comb begin
    crc_acc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if ((crc_acc[4] ^ data_in[i]) == 1'b1) begin
        crc_acc = {crc_acc[3:0], 1'b0} ^ CRC5_POLY;
      end else begin
        crc_acc = {crc_acc[3:0], 1'b0};
      end
    end
    crc_out = crc_acc;
  end

endmodule

// File: rtl/usb_dev_token_decoder.sv
// -----------------------------------------------------------------------------
// usb_dev_token_decoder
// Device-side receiver for token packets (OUT/IN/SETUP/SOF) arriving on the
// UTMI Rx interface. Checks PID complement, packet length, CRC5 and device
// address, then presents the decoded fields with a one-cycle strobe.
// Non-token PIDs are flagged on data_pid_valid and the rest of the packet is
// drained.
//
// Parameters
//   CHECK_ADDR      1: IN/OUT/SETUP must match dev_addr; 0: accept any address
// Ports
//   clk             UTMI clock
//   reset           asynchronous active-high reset
//   dev_addr[6:0]   assigned device address (sampled when a token completes)
//   Rx_active       UTMI packet framing
//   Rx_Valid        UTMI_Rx_Data carries a byte this cycle
//   Rx_error        UTMI receive error
//   UTMI_Rx_Data    received byte, first byte of a packet is the PID
//   token_valid     strobe: good, address-matched IN/OUT/SETUP
//   sof_valid       strobe: good SOF
//   token_pid[3:0]  PID of last accepted token or flagged non-token PID
//   token_addr[6:0] address of last accepted token
//   token_endp[3:0] endpoint of last accepted token
//   frame_no[10:0]  frame number of last good SOF
//   data_pid_valid  strobe: valid non-token PID, value on token_pid
//   pid_error       strobe: bad PID complement or reserved/PRE PID
//   crc5_error      strobe: token CRC5 residual mismatch
//   len_error       strobe: token without exactly two bytes after the PID
//   rx_abort        strobe: Rx_error during a packet
// -----------------------------------------------------------------------------
module usb_dev_token_decoder
  import usb_pkg::*;
#(
  parameter bit CHECK_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  dev_addr,
  input  logic        Rx_active,
  input  logic        Rx_Valid,
  input  logic        Rx_error,
  input  logic [7:0]  UTMI_Rx_Data,
  output logic        token_valid,
  output logic        sof_valid,
  output logic [3:0]  token_pid,
  output logic [6:0]  token_addr,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_no,
  output logic        data_pid_valid,
  output logic        pid_error,
  output logic        crc5_error,
  output logic        len_error,
  output logic        rx_abort
);

  tok_state_e  state_q, state_d;
  logic [3:0]  pid_q, pid_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;
  logic [4:0]  crc_q, crc_d;
  // Set once Rx_active has been seen low since reset, so a packet already in
  // flight when reset released is drained instead of being parsed mid-stream.
  logic        armed_q, armed_d;

  logic        token_valid_q, token_valid_d;
  logic        sof_valid_q, sof_valid_d;
  logic        data_pid_valid_q, data_pid_valid_d;
  logic        pid_error_q, pid_error_d;
  logic        crc5_error_q, crc5_error_d;
  logic        len_error_q, len_error_d;
  logic        rx_abort_q, rx_abort_d;
  logic [3:0]  token_pid_q, token_pid_d;
  logic [6:0]  token_addr_q, token_addr_d;
  logic [3:0]  token_endp_q, token_endp_d;
  logic [10:0] frame_no_q, frame_no_d;

  logic [4:0]  crc_byte_out;
  logic        pid_bad_cpl;

  usb_crc5_byte u_crc5 (
    .crc_in  (crc_q),
    .data_in (UTMI_Rx_Data),
    .crc_out (crc_byte_out)
  );

  assign pid_bad_cpl = (UTMI_Rx_Data[7:4] != ~UTMI_Rx_Data[3:0]);

  // Next-state, capture and strobe logic for the token FSM.
  always_comb begin
    state_d          = state_q;
    pid_d            = pid_q;
    b1_d             = b1_q;
    b2_d             = b2_q;
    crc_d            = crc_q;
    armed_d          = armed_q | ~Rx_active;
    token_valid_d    = 1'b0;
    sof_valid_d      = 1'b0;
    data_pid_valid_d = 1'b0;
    pid_error_d      = 1'b0;
    crc5_error_d     = 1'b0;
    len_error_d      = 1'b0;
    rx_abort_d       = 1'b0;
    token_pid_d      = token_pid_q;
    token_addr_d     = token_addr_q;
    token_endp_d     = token_endp_q;
    frame_no_d       = frame_no_q;

    case (state_q)
      ST_IDLE: begin
        if (Rx_active) begin
          state_d = armed_q ? ST_PID : ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PID: begin
        if (!Rx_active) begin
          state_d = ST_IDLE;
        end else if (Rx_error) begin
          rx_abort_d = 1'b1;
          state_d    = ST_DRAIN;
        end else if (Rx_Valid) begin
          if (pid_bad_cpl || is_illegal_pid(UTMI_Rx_Data[3:0])) begin
            pid_error_d = 1'b1;
            state_d     = ST_DRAIN;
          end else if (is_token_pid(UTMI_Rx_Data[3:0])) begin
            pid_d   = UTMI_Rx_Data[3:0];
            crc_d   = CRC5_INIT;
            state_d = ST_B1;
          end else begin
            data_pid_valid_d = 1'b1;
            token_pid_d      = UTMI_Rx_Data[3:0];
            state_d          = ST_DRAIN;
          end
        end else begin
          state_d = ST_PID;
        end
      end

      ST_B1: begin
        if (!Rx_active) begin
          len_error_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (Rx_error) begin
          rx_abort_d = 1'b1;
          state_d    = ST_DRAIN;
        end else if (Rx_Valid) begin
          b1_d    = UTMI_Rx_Data;
          crc_d   = crc_byte_out;
          state_d = ST_B2;
        end else begin
          state_d = ST_B1;
        end
      end

      ST_B2: begin
        if (!Rx_active) begin
          len_error_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (Rx_error) begin
          rx_abort_d = 1'b1;
          state_d    = ST_DRAIN;
        end else if (Rx_Valid) begin
          b2_d    = UTMI_Rx_Data;
          crc_d   = crc_byte_out;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_B2;
        end
      end

      // Both bytes are in; wait for end of packet, then judge the token.
      ST_CHECK: begin
        if (Rx_active) begin
          if (Rx_error) begin
            rx_abort_d = 1'b1;
            state_d    = ST_DRAIN;
          end else if (Rx_Valid) begin
            len_error_d = 1'b1;
            state_d     = ST_DRAIN;
          end else begin
            state_d = ST_CHECK;
          end
        end else begin
          state_d = ST_IDLE;
          if (crc_q != CRC5_RESIDUAL) begin
            crc5_error_d = 1'b1;
          end else if (pid_q == PID_SOF) begin
            sof_valid_d = 1'b1;
            frame_no_d  = {b2_q[2:0], b1_q};
          end else if ((CHECK_ADDR == 1'b0) || (b1_q[6:0] == dev_addr)) begin
            token_valid_d = 1'b1;
            token_pid_d   = pid_q;
            token_addr_d  = b1_q[6:0];
            token_endp_d  = {b2_q[2:0], b1_q[7]};
          end else begin
            // Token for another device: dropped without any strobe.
            token_valid_d = 1'b0;
          end
        end
      end

      // Swallow the remainder of a packet; errors here were already reported
      // or are irrelevant, so no further strobe is raised.
      ST_DRAIN: begin
        if (Rx_active) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, byte buffers, CRC and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      pid_q            <= 4'd0;
      b1_q             <= 8'd0;
      b2_q             <= 8'd0;
      crc_q            <= 5'd0;
      armed_q          <= 1'b0;
      token_valid_q    <= 1'b0;
      sof_valid_q      <= 1'b0;
      data_pid_valid_q <= 1'b0;
      pid_error_q      <= 1'b0;
      crc5_error_q     <= 1'b0;
      len_error_q      <= 1'b0;
      rx_abort_q       <= 1'b0;
      token_pid_q      <= 4'd0;
      token_addr_q     <= 7'd0;
      token_endp_q     <= 4'd0;
      frame_no_q       <= 11'd0;
    end else begin
      state_q          <= state_d;
      pid_q            <= pid_d;
      b1_q             <= b1_d;
      b2_q             <= b2_d;
      crc_q            <= crc_d;
      armed_q          <= armed_d;
      token_valid_q    <= token_valid_d;
      sof_valid_q      <= sof_valid_d;
      data_pid_valid_q <= data_pid_valid_d;
      pid_error_q      <= pid_error_d;
      crc5_error_q     <= crc5_error_d;
      len_error_q      <= len_error_d;
      rx_abort_q       <= rx_abort_d;
      token_pid_q      <= token_pid_d;
      token_addr_q     <= token_addr_d;
      token_endp_q     <= token_endp_d;
      frame_no_q       <= frame_no_d;
    end
  end

  assign token_valid    = token_valid_q;
  assign sof_valid      = sof_valid_q;
  assign data_pid_valid = data_pid_valid_q;
  assign pid_error      = pid_error_q;
  assign crc5_error     = crc5_error_q;
  assign len_error      = len_error_q;
  assign rx_abort       = rx_abort_q;
  assign token_pid      = token_pid_q;
  assign token_addr     = token_addr_q;
  assign token_endp     = token_endp_q;
  assign frame_no       = frame_no_q;

endmodule

// File: tb/tb_usb_dev_token_decoder.sv
// -----------------------------------------------------------------------------
// tb_usb_dev_token_decoder
// Drives directed and random UTMI packets into two decoder instances (address
// checking on and off) and compares per-packet strobe counts, strobe timing
// and held fields against a packet-level reference model.
// -----------------------------------------------------------------------------
module tb_usb_dev_token_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  dev_addr;
  logic        rx_active, rx_valid, rx_error;
  logic [7:0]  rx_data;

  logic [1:0]  tv, sofv, dpv, pide, crce, lene, abrt;
  logic [3:0]  tpid  [2];
  logic [6:0]  taddr [2];
  logic [3:0]  tendp [2];
  logic [10:0] tfrm  [2];

  always #5 clk = ~clk;

  usb_dev_token_decoder #(.CHECK_ADDR(1'b1)) dut_chk (
    .clk(clk), .reset(reset), .dev_addr(dev_addr), .Rx_active(rx_active),
    .Rx_Valid(rx_valid), .Rx_error(rx_error), .UTMI_Rx_Data(rx_data),
    .token_valid(tv[0]), .sof_valid(sofv[0]), .token_pid(tpid[0]),
    .token_addr(taddr[0]), .token_endp(tendp[0]), .frame_no(tfrm[0]),
    .data_pid_valid(dpv[0]), .pid_error(pide[0]), .crc5_error(crce[0]),
    .len_error(lene[0]), .rx_abort(abrt[0]));

  usb_dev_token_decoder #(.CHECK_ADDR(1'b0)) dut_snf (
    .clk(clk), .reset(reset), .dev_addr(dev_addr), .Rx_active(rx_active),
    .Rx_Valid(rx_valid), .Rx_error(rx_error), .UTMI_Rx_Data(rx_data),
    .token_valid(tv[1]), .sof_valid(sofv[1]), .token_pid(tpid[1]),
    .token_addr(taddr[1]), .token_endp(tendp[1]), .frame_no(tfrm[1]),
    .data_pid_valid(dpv[1]), .pid_error(pide[1]), .crc5_error(crce[1]),
    .len_error(lene[1]), .rx_abort(abrt[1]));

  int n_cmp = 0;
  int n_mis = 0;
  int tick_no = 0;
  int fall_tick;
  int cnt [2][7];          // strobe counts: 0 tok,1 sof,2 dpid,3 pid,4 crc,5 len,6 abort
  int first_tick [2];

  logic [7:0] pkt [$];
  int cur_err, cur_rst;

  int exp_kind [2];
  bit exp_lat;
  logic [3:0]  exp_pid   [2] = '{4'd0, 4'd0};
  logic [6:0]  exp_addr  [2] = '{7'd0, 7'd0};
  logic [3:0]  exp_endp  [2] = '{4'd0, 4'd0};
  logic [10:0] exp_frame [2] = '{11'd0, 11'd0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string stb_name(input int k);
    case (k)
      0: return "token_valid";
      1: return "sof_valid";
      2: return "data_pid_valid";
      3: return "pid_error";
      4: return "crc5_error";
      5: return "len_error";
      default: return "rx_abort";
    endcase
  endfunction

  // CRC5 field for 11 data bits by polynomial long division: first wire bit
  // is the highest-degree coefficient, the all-ones preset complements the
  // top five, and the complemented remainder goes out x^4 coefficient first.
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [15:0] v;
    logic [4:0]  r, f;
    v = 16'd0;
    for (int k = 0; k < 11; k++) v[15-k] = d[k];
    v[15:11] = v[15:11] ^ 5'h1F;
    for (int k = 15; k >= 5; k--) if (v[k]) v = v ^ (16'h0025 << (k - 5));
    r = v[4:0];
    for (int j = 0; j < 5; j++) f[j] = ~r[4-j];
    return f;
  endfunction

  task automatic build_token(input logic [3:0] pid, input logic [10:0] d);
    logic [4:0] f;
    f = crc5_field(d);
    pkt.delete();
    pkt.push_back({~pid, pid});
    pkt.push_back(d[7:0]);
    pkt.push_back({f, d[10:8]});
  endtask

  // One clock; sample both instances 1 time unit after the rising edge.
  task automatic tick();
    logic [6:0] s;
    @(posedge clk);
    #1;
    tick_no++;
    for (int i = 0; i < 2; i++) begin
      s = {abrt[i], lene[i], crce[i], pide[i], dpv[i], sofv[i], tv[i]};
      for (int k = 0; k < 7; k++) begin
        if (s[k]) begin
          cnt[i][k]++;
          if (first_tick[i] < 0) first_tick[i] = tick_no;
        end
      end
    end
  endtask

  // Packet-level reference: what each instance must report for pkt.
  task automatic model_packet();
    int n, m;
    logic [7:0]  p;
    logic [10:0] d;
    n = pkt.size();
    exp_lat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_kind[i] = -1;
      if (cur_rst >= 0) begin
        exp_pid[i] = 4'd0; exp_addr[i] = 7'd0; exp_endp[i] = 4'd0; exp_frame[i] = 11'd0;
        continue;
      end
      m = (cur_err >= 0) ? cur_err : n;
      if (m == 0) begin
        if (cur_err >= 0) exp_kind[i] = 6;
        continue;
      end
      p = pkt[0];
      if ((p[7:4] != ~p[3:0]) || (p[3:0] == 4'h0) || (p[3:0] == 4'hC)) begin
        exp_kind[i] = 3;
      end else if (!(p[3:0] inside {4'h1, 4'h9, 4'hD, 4'h5})) begin
        exp_kind[i] = 2;
        exp_pid[i]  = p[3:0];
      end else if (cur_err >= 0) begin
        exp_kind[i] = (m <= 3) ? 6 : 5;
      end else if (n != 3) begin
        exp_kind[i] = 5;
      end else begin
        d = {pkt[2][2:0], pkt[1]};
        exp_lat = 1'b1;
        if (pkt[2][7:3] != crc5_field(d)) begin
          exp_kind[i] = 4;
        end else if (p[3:0] == 4'h5) begin
          exp_kind[i] = 1;
          exp_frame[i] = d;
        end else if ((i == 1) || (pkt[1][6:0] == dev_addr)) begin
          exp_kind[i] = 0;
          exp_pid[i]  = p[3:0];
          exp_addr[i] = pkt[1][6:0];
          exp_endp[i] = {pkt[2][2:0], pkt[1][7]};
        end
      end
    end
  endtask

  task automatic send_packet();
    int n;
    n = pkt.size();
    for (int i = 0; i < 2; i++) begin
      first_tick[i] = -1;
      for (int k = 0; k < 7; k++) cnt[i][k] = 0;
    end
    rx_active = 1'b1;
    tick();
    for (int i = 0; i <= n; i++) begin
      if (i == cur_err) begin
        rx_error = 1'b1; tick(); rx_error = 1'b0;
        break;
      end
      if (i == n) break;
      if (i == cur_rst) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      rx_valid = 1'b1; rx_data = pkt[i];
      tick();
      rx_valid = 1'b0; rx_data = 8'($urandom);
      repeat ($urandom_range(0, 2)) tick();
    end
    rx_active = 1'b0;
    tick();
    fall_tick = tick_no;
    for (int j = 0; j < 3; j++) begin
      // Stray Rx_Valid outside a packet must be ignored.
      if (j == 1 && $urandom_range(0, 1) == 1) begin
        rx_valid = 1'b1; rx_data = 8'($urandom);
      end
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic run_packet(input string tag);
    string nm;
    model_packet();
    send_packet();
    for (int i = 0; i < 2; i++) begin
      nm = $sformatf("%s.%s", tag, (i == 0) ? "chk" : "snf");
      for (int k = 0; k < 7; k++)
        check_eq({nm, ".", stb_name(k)}, cnt[i][k], (exp_kind[i] == k) ? 1 : 0);
      if (exp_lat && exp_kind[i] >= 0)
        check_eq({nm, ".latency"}, first_tick[i], fall_tick);
      check_eq({nm, ".token_pid"},  tpid[i],  exp_pid[i]);
      check_eq({nm, ".token_addr"}, taddr[i], exp_addr[i]);
      check_eq({nm, ".token_endp"}, tendp[i], exp_endp[i]);
      check_eq({nm, ".frame_no"},   tfrm[i],  exp_frame[i]);
    end
  endtask

  task automatic directed(input string tag, input logic [6:0] da, input int err, input int rst);
    dev_addr = da; cur_err = err; cur_rst = rst;
    run_packet(tag);
  endtask

  initial begin
    logic [6:0]  da, a;
    logic [3:0]  tp;
    int          sel, idx;
    logic [3:0]  tok_pids [4] = '{4'h1, 4'h9, 4'hD, 4'h5};
    logic [3:0]  dat_pids [8] = '{4'h3, 4'hB, 4'h7, 4'hF, 4'h2, 4'hA, 4'hE, 4'h6};

    reset = 1'b1; dev_addr = 7'd0; rx_active = 1'b0; rx_valid = 1'b0;
    rx_error = 1'b0; rx_data = 8'd0;
    for (int i = 0; i < 2; i++) first_tick[i] = -1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check_eq("reset.strobes", {abrt[i], lene[i], crce[i], pide[i], dpv[i], sofv[i], tv[i]}, 32'd0);
      check_eq("reset.token_pid", tpid[i], 32'd0);
      check_eq("reset.token_addr", taddr[i], 32'd0);
      check_eq("reset.token_endp", tendp[i], 32'd0);
      check_eq("reset.frame_no", tfrm[i], 32'd0);
    end
    reset = 1'b0;
    tick();

    build_token(4'hD, 11'h000);                 directed("setup0", 7'd0, -1, -1);
    build_token(4'h9, 11'h000);                 directed("in_other", 7'd5, -1, -1);
    build_token(4'h5, 11'h000);                 directed("sof0", 7'd0, -1, -1);
    pkt = '{8'h2D, 8'h00, 8'h11};               directed("crc_bad", 7'd0, -1, -1);
    pkt = '{8'h2C, 8'h00, 8'h10};               directed("pid_bad", 7'd0, -1, -1);
    pkt = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44}; directed("data0", 7'd0, -1, -1);
    pkt = '{8'h2D, 8'h00};                      directed("short", 7'd0, -1, -1);
    pkt = '{8'h2D, 8'h00, 8'h10, 8'hFF};        directed("long", 7'd0, -1, -1);
    pkt = '{8'h2D, 8'h00, 8'h10};               directed("abort", 7'd0, 2, -1);
    pkt = '{8'h2D, 8'h00, 8'h10};               directed("rst_mid", 7'd0, -1, 2);
    build_token(4'h9, 11'h000);                 directed("in_after_rst", 7'd0, -1, -1);

    da = 7'd5;
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 3) == 0) da = 7'($urandom);
      cur_err = -1; cur_rst = -1;
      a  = ($urandom_range(0, 1) == 1) ? da : 7'($urandom);
      tp = tok_pids[$urandom_range(0, 3)];
      build_token(tp, {4'($urandom), a});
      sel = $urandom_range(0, 9);
      case (sel)
        4: begin
          idx = $urandom_range(1, 2);
          pkt[idx] = pkt[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
        5: begin
          pkt.delete();
          pkt.push_back(8'($urandom));
          repeat ($urandom_range(0, 4)) pkt.push_back(8'($urandom));
        end
        6: begin
          tp = dat_pids[$urandom_range(0, 7)];
          pkt.delete();
          pkt.push_back({~tp, tp});
          repeat ($urandom_range(0, 5)) pkt.push_back(8'($urandom));
        end
        7: begin
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) void'(pkt.pop_back());
          end else begin
            repeat ($urandom_range(1, 2)) pkt.push_back(8'($urandom));
          end
        end
        8: cur_err = $urandom_range(0, pkt.size());
        9: cur_rst = $urandom_range(1, 2);
        default: ;
      endcase
      dev_addr = da;
      run_packet($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
